// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encoding and counter sizing for the PISO shifter
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit counter width: wide enough to hold WIDTH without wrapping inside a frame.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_bitcnt.sv
// rtl/piso_bitcnt.sv - loadable bit counter with enable, clear and terminal-count compare
module piso_bitcnt #(
    parameter int CW = 4,
    parameter int TC = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          ld_i,
    input  logic [CW-1:0] ld_val_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins over load, load wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == CW'(TC));

endmodule

// File: rtl/piso_shifter.sv
// rtl/piso_shifter.sv - parallel-in serial-out shifter, MSB first; PISO_PARITY_EN appends even parity
module piso_shifter
    import piso_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    output logic             load_ready,
    input  logic             enable,
    output logic             sout,
    output logic             sout_valid,
    output logic             last
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = cnt_width(WIDTH);

    state_t                 state_q;
    state_t                 state_d;
    logic [FRAME_LEN-1:0]   sreg_q;
    logic [FRAME_LEN-1:0]   sreg_d;
    logic [FRAME_LEN-1:0]   frame_w;
    logic [CW-1:0]          cnt_w;
    logic                   tc_w;
    logic                   cnt_clr;
    logic                   cnt_en;

    // The parity bit rides in the shift register's LSB so it leaves right after d[0].
`ifdef PISO_PARITY_EN
    assign frame_w = {d, ^d};
`else
    assign frame_w = d;
`endif

    // FSM next state, shift-register next value and counter controls.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SHIFT;
                    sreg_d  = frame_w;
                    cnt_clr = 1'b1;
                end
            end
            SHIFT: begin
                if (enable) begin
                    sreg_d = {sreg_q[FRAME_LEN-2:0], 1'b0};
                    cnt_en = 1'b1;
                    if (tc_w) begin
                        state_d = IDLE;
                        cnt_clr = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and shift register; reset forces an idle, all-zero shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
        end
    end

    piso_bitcnt #(
        .CW (CW),
        .TC (FRAME_LEN - 1)
    ) u_bitcnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (cnt_clr),
        .ld_i     (1'b0),
        .ld_val_i ({CW{1'b0}}),
        .en_i     (cnt_en),
        .cnt_o    (cnt_w),
        .tc_o     (tc_w)
    );

    // Outputs are gated by state so IDLE always shows sout = 0 and last = 0.
    assign load_ready = (state_q == IDLE);
    assign sout_valid = (state_q == SHIFT);
    assign sout       = sout_valid & sreg_q[FRAME_LEN-1];
    assign last       = sout_valid & tc_w;

    logic unused_cnt;
    assign unused_cnt = ^cnt_w;

endmodule

// File: tb/tb_piso_shifter.sv
// tb/tb_piso_shifter.sv - scoreboard bench for piso_shifter at WIDTH=8 and WIDTH=32
module tb_piso_shifter;

`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load8 = 1'b0;
    logic [7:0]  d8 = '0;
    logic        load32 = 1'b0;
    logic [31:0] d32 = '0;
    logic        load_ready8, sout8, sout_valid8, last8;
    logic        load_ready32, sout32, sout_valid32, last32;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]  q8[$];
    logic [31:0] q32[$];
    bit          busy8 = 1'b0;
    logic [32:0] acc32 = '0;

    piso_shifter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .d(d8), .load(load8), .load_ready(load_ready8),
        .enable(enable), .sout(sout8), .sout_valid(sout_valid8), .last(last8)
    );

    piso_shifter #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .d(d32), .load(load32), .load_ready(load_ready32),
        .enable(enable), .sout(sout32), .sout_valid(sout_valid32), .last(last32)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected 8-bit frame as {bit, last} entries, MSB first, optional parity at the end.
    task automatic push8(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            q8.push_back({w[i], (i == 0 && PAR == 0) ? 1'b1 : 1'b0});
        end
        if (PAR != 0) q8.push_back({^w, 1'b1});
    endtask

    // One clock: sample at negedge, compare, drive next inputs, advance the models.
    task automatic cyc(input logic ld, input logic [7:0] dd, input logic en);
        logic [1:0]  e;
        logic [31:0] w;
        @(negedge clk);
        check("rdy8", load_ready8, !busy8);
        check("vld8", sout_valid8, busy8);
        if (busy8 && q8.size() > 0) begin
            e = q8[0];
            check("sout8", sout8, e[1]);
            check("last8", last8, e[0]);
        end else begin
            check("sout8_idle", sout8, 1'b0);
            check("last8_idle", last8, 1'b0);
        end
        load8  = ld;
        d8     = dd;
        enable = en;
        if (rst_n) begin
            if (busy8) begin
                if (en && q8.size() > 0) begin
                    e = q8.pop_front();
                    if (e[0]) busy8 = 1'b0;
                end
            end else if (ld) begin
                push8(dd);
                busy8 = 1'b1;
            end
        end
        if (sout_valid32 && en) begin
            acc32 = {acc32[31:0], sout32};
            if (last32) begin
                if (q32.size() == 0) begin
                    check("q32_underflow", 1'b1, 1'b0);
                end else begin
                    w = q32.pop_front();
`ifdef PISO_PARITY_EN
                    check("word32", acc32[32:1], w);
                    check("par32", acc32[0], ^w);
`else
                    check("word32", acc32[31:0], w);
`endif
                end
                acc32 = '0;
            end
        end
    endtask

    initial begin
        logic [31:0] w;
        int guard;
        // Reset held: outputs idle, and a load during reset is not accepted.
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'h55, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        rst_n = 1'b1;

        // A5 with enable held high.
        cyc(1'b1, 8'hA5, 1'b1);
        repeat (11) cyc(1'b0, 8'h00, 1'b1);

        // 81 with enable toggling.
        cyc(1'b1, 8'h81, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00, (i % 2 == 1));
        repeat (3) cyc(1'b0, 8'h00, 1'b1);

        // Parity-sensitive words.
        cyc(1'b1, 8'h07, 1'b1);
        repeat (11) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h03, 1'b1);
        repeat (11) cyc(1'b0, 8'h00, 1'b1);

        // FF frame while load with 00 is held: 00 only taken once ready returns.
        cyc(1'b1, 8'hFF, 1'b1);
        repeat (12) cyc(1'b1, 8'h00, 1'b1);
        repeat (12) cyc(1'b0, 8'h00, 1'b1);

        // Asynchronous reset mid-frame after the third bit, then a fresh 3C frame.
        cyc(1'b1, 8'hC6, 1'b1);
        repeat (3) cyc(1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_vld8", sout_valid8, 1'b0);
        check("rst_sout8", sout8, 1'b0);
        check("rst_last8", last8, 1'b0);
        check("rst_rdy8", load_ready8, 1'b1);
        q8.delete();
        busy8 = 1'b0;
        #1 rst_n = 1'b1;
        cyc(1'b1, 8'h3C, 1'b1);
        repeat (12) cyc(1'b0, 8'h00, 1'b1);

        // Random words with random enable.
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 8'($urandom), 1'b1);
            guard = 0;
            while (busy8 && guard < 200) begin
                cyc(1'b0, 8'h00, 1'($urandom_range(0, 1)));
                guard++;
            end
            check("rand8_done", busy8, 1'b0);
            cyc(1'b0, 8'h00, 1'b1);
        end

        // 32-bit random loads reassembled from sout.
        for (int k = 0; k < 20; k++) begin
            w = $urandom;
            cyc(1'b0, 8'h00, 1'b1);
            load32 = 1'b1;
            d32    = w;
            q32.push_back(w);
            cyc(1'b0, 8'h00, 1'b1);
            load32 = 1'b0;
            repeat (35) cyc(1'b0, 8'h00, 1'b1);
        end

        check("q8_empty", q8.size(), 0);
        check("q32_empty", q32.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
